muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer for the multicycle MIPS core. It implements MULT, MULTU, DIV and DIVU with a start/done handshake, and owns the architectural HI/LO registers. The control unit (UC) pulses Start from its execute state and holds in a wait state until Done. The register-bank write-data mux reads Hi and Lo for MFHI/MFLO.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_step.sv | 34 +++
 rtl/muldiv_seq.sv | 118 +++++++++++
 tb/tb_muldiv_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;
  localparam int MULDIV_CNT_W = $clog2(MULDIV_WIDTH);

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply (LSB first) or
// restoring shift-subtract divide (MSB first) on the upper accumulator half.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               in_bit,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (in_bit ? opnd : '0)};
    rem_sh = {acc[2*WIDTH-1:WIDTH], in_bit};
    diff   = rem_sh - {1'b0, opnd};
    if (is_div) begin
      // Borrow out of the WIDTH+1 bit subtract means the divisor did not fit.
      q_bit    = ~diff[WIDTH];
      acc_next = {(q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-1:0]};
    end else begin
      q_bit    = 1'b0;
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// MULT/MULTU/DIV/DIVU sequencer with start/done handshake; owns HI/LO.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t      state;
  muldiv_op_t         op_r;
  logic [WIDTH-1:0]   a_r, b_r, abs_a, abs_b;
  logic [WIDTH-1:0]   opnd, shf, q_fix, r_fix;
  logic [2*WIDTH-1:0] acc, acc_next, prod_fix;
  logic [CW-1:0]      cnt;
  logic               sa, sb, is_div, is_sgn, in_bit, q_bit;

  assign is_div = (op_r == DIV) || (op_r == DIVU);
  assign is_sgn = (op_r == MULT) || (op_r == DIV);
  assign abs_a  = (is_sgn && a_r[WIDTH-1]) ? -a_r : a_r;
  assign abs_b  = (is_sgn && b_r[WIDTH-1]) ? -b_r : b_r;
  // shf holds the multiplier (shifting right) or the dividend, which is
  // replaced by the quotient as bits shift out the top.
  assign in_bit = is_div ? shf[WIDTH-1] : shf[0];

  assign prod_fix = (sa ^ sb) ? -acc : acc;
  assign q_fix    = (sa ^ sb) ? -shf : shf;
  assign r_fix    = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign Busy = (state != IDLE);
  assign Done = (state == DONE);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .opnd     (opnd),
    .in_bit   (in_bit),
    .is_div   (is_div),
    .acc_next (acc_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state   <= IDLE;
      op_r    <= MULT;
      a_r     <= '0;
      b_r     <= '0;
      opnd    <= '0;
      shf     <= '0;
      sa      <= 1'b0;
      sb      <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      DivZero <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          op_r  <= muldiv_op_t'(Op);
          a_r   <= A;
          b_r   <= B;
          state <= PREP;
        end
        PREP: begin
          sa   <= is_sgn & a_r[WIDTH-1];
          sb   <= is_sgn & b_r[WIDTH-1];
          opnd <= is_div ? abs_b : abs_a;
          shf  <= is_div ? abs_a : abs_b;
          acc  <= '0;
          cnt  <= '0;
          if (is_div && (b_r == '0)) begin
            Hi      <= a_r;
            Lo      <= '1;
            DivZero <= 1'b1;
            state   <= DONE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          shf <= is_div ? {shf[WIDTH-2:0], q_bit} : {1'b0, shf[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            Hi <= r_fix;
            Lo <= q_fix;
          end else begin
            Hi <= prod_fix[2*WIDTH-1:WIDTH];
            Lo <= prod_fix[WIDTH-1:0];
          end
          state <= DONE;
        end
        DONE: begin
          DivZero <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed table, handshake corner cases,
// and random operations against an arithmetic reference model.
module tb_muldiv_seq;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] A = '0, B = '0;
  logic        Busy, Done, DivZero;
  logic [31:0] Hi, Lo;

  int checks = 0;
  int failures = 0;

  muldiv_seq dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic dz, output int lat);
    logic [63:0] p;
    longint      x, y, q, r;
    dz = 1'b0; lat = 35; hi = '0; lo = '0;
    case (op)
      2'd0: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        hi = p[63:32]; lo = p[31:0];
      end
      2'd1: begin
        p = {32'b0, a} * {32'b0, b};
        hi = p[63:32]; lo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          dz = 1'b1; lat = 2; hi = a; lo = '1;
        end else begin
          if (op == 2'd2) begin
            x = longint'($signed(a)); y = longint'($signed(b));
          end else begin
            x = longint'({32'b0, a}); y = longint'({32'b0, b});
          end
          q = x / y; r = x % y;
          lo = q[31:0]; hi = r[31:0];
        end
      end
    endcase
  endfunction

  // Issue one op, wait (bounded) for Done; reports latency and handshake health.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] hi, output logic [31:0] lo,
                        output logic dz, output logic busy_ok, output logic idle_ok);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk);
    #1 Start = 1'b0;
    lat = -1; busy_ok = 1'b1; hi = '0; lo = '0; dz = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge Clk);
      if (!Busy) busy_ok = 1'b0;
      if (Done) begin
        lat = c; hi = Hi; lo = Lo; dz = DivZero;
        break;
      end
    end
    @(negedge Clk);
    idle_ok = !Busy && !Done && !DivZero;
  endtask

  task automatic run_and_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    logic [31:0] eh, el, ah, al;
    logic        ed, ad, bok, iok;
    int          elat, alat;
    model(op, a, b, eh, el, ed, elat);
    run_op(op, a, b, alat, ah, al, ad, bok, iok);
    chk({tag, ".latency"}, 64'(alat), 64'(elat));
    chk({tag, ".hi"}, 64'(ah), 64'(eh));
    chk({tag, ".lo"}, 64'(al), 64'(el));
    chk({tag, ".divzero"}, 64'(ad), 64'(ed));
    chk({tag, ".busy"}, 64'(bok), 64'd1);
    chk({tag, ".idle_after"}, 64'(iok), 64'd1);
  endtask

  initial begin
    logic [31:0] ah, al, ra, rb;
    logic [1:0]  rop;
    logic        ad, bok, iok, seen;
    int          alat;

    // Directed table (expected values worked out by hand).
    vt[0] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vt[1] = '{2'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vt[2] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vt[3] = '{2'd3, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1};
    vt[4] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vt[5] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vt[6] = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vt[7] = '{2'd2, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
    vt[8] = '{2'd3, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999, 1'b0};
    vt[9] = '{2'd1, 32'h12345678, 32'h00000002, 32'h00000000, 32'h2468ACF0, 1'b0};

    // Reset state.
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("reset.busy", 64'(Busy), 64'd0);
    chk("reset.done", 64'(Done), 64'd0);
    chk("reset.divzero", 64'(DivZero), 64'd0);
    chk("reset.hi", 64'(Hi), 64'd0);
    chk("reset.lo", 64'(Lo), 64'd0);
    Reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, alat, ah, al, ad, bok, iok);
      chk($sformatf("vec%0d.latency", i), 64'(alat),
          (vt[i].dz ? 64'd2 : 64'd35));
      chk($sformatf("vec%0d.hi", i), 64'(ah), 64'(vt[i].hi));
      chk($sformatf("vec%0d.lo", i), 64'(al), 64'(vt[i].lo));
      chk($sformatf("vec%0d.divzero", i), 64'(ad), 64'(vt[i].dz));
      chk($sformatf("vec%0d.busy", i), 64'(bok), 64'd1);
      chk($sformatf("vec%0d.idle_after", i), 64'(iok), 64'd1);
    end

    // Start re-pulsed while busy must be ignored: result and latency untouched.
    @(negedge Clk);
    Start = 1'b1; Op = 2'd1; A = 32'd3; B = 32'd4;
    @(posedge Clk);
    #1 Start = 1'b0;
    alat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge Clk);
      if (c == 4) begin Start = 1'b1; A = 32'd7; B = 32'd7; end
      if (c == 5) Start = 1'b0;
      if (Done) begin alat = c; ah = Hi; al = Lo; break; end
    end
    chk("ignore.latency", 64'(alat), 64'd35);
    chk("ignore.hi", 64'(ah), 64'd0);
    chk("ignore.lo", 64'(al), 64'd12);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (Done || Busy) seen = 1'b1;
    end
    chk("ignore.no_second_op", 64'(seen), 64'd0);

    // Abort mid-RUN with reset; Hi/Lo currently hold 0/12 from above.
    @(negedge Clk);
    Start = 1'b1; Op = 2'd0; A = 32'd3; B = 32'd5;
    @(posedge Clk);
    #1 Start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge Clk);
      if (c == 4) begin Start = 1'b1; Op = 2'd3; A = 32'd100; B = 32'd3; end
      if (c == 5) Start = 1'b0;
      if (c == 9) Reset = 1'b0;
    end
    @(negedge Clk);
    chk("abort.busy", 64'(Busy), 64'd0);
    chk("abort.done", 64'(Done), 64'd0);
    chk("abort.divzero", 64'(DivZero), 64'd0);
    chk("abort.hi", 64'(Hi), 64'd0);
    chk("abort.lo", 64'(Lo), 64'd0);
    Reset = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (Done) seen = 1'b1;
    end
    chk("abort.no_done", 64'(seen), 64'd0);
    run_op(2'd3, 32'd9, 32'd4, alat, ah, al, ad, bok, iok);
    chk("after_abort.latency", 64'(alat), 64'd35);
    chk("after_abort.lo", 64'(al), 64'd2);
    chk("after_abort.hi", 64'(ah), 64'd1);
    chk("after_abort.divzero", 64'(ad), 64'd0);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 50));
      run_and_check($sformatf("rand%0d", i), rop, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
